// File: rtl/lwe_vector_engine.sv
// lwe_vector_engine: multi-lane LWE ciphertext engine.
// Streams ciphertext vectors LANES entries per beat. Each command runs one of:
//   ADD (elementwise x+y mod q), SUB (elementwise x-y mod q),
//   DEC (b - sum a_j*s_j mod q, then round to a PW-bit plaintext).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, mode     command strobe (sampled in IDLE) and operation select
//   clear           synchronous abort back to IDLE
//   busy, err       engine active; one-cycle pulse for reserved mode
//   in_valid/ready  operand beat handshake, in_x / in_y lane payloads
//   out_valid/ready result beat handshake, out_data payload, out_last marker
module lwe_vector_engine #(
  parameter int unsigned PLAINTEXT_WIDTH  = 6,
  parameter int unsigned CIPHERTEXT_WIDTH = 10,
  parameter int unsigned DIMENSION        = 10,
  parameter int unsigned LANES            = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [1:0]                          mode,
  input  logic                                clear,
  output logic                                busy,
  output logic                                err,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   in_x,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   in_y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*CIPHERTEXT_WIDTH-1:0]   out_data,
  output logic                                out_last
);

  localparam int unsigned CW      = CIPHERTEXT_WIDTH;
  localparam int unsigned PW      = PLAINTEXT_WIDTH;
  localparam int unsigned DW      = LANES * CW;
  localparam int unsigned ENTRIES = DIMENSION + 1;
  localparam int unsigned BEATS   = (ENTRIES + LANES - 1) / LANES;
  localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) + 1 : 1;
  localparam int unsigned IDX_W   = $clog2(BEATS * LANES) + 1;
  localparam int unsigned SHIFT   = CW - PW;
  localparam logic [CW-1:0] ROUND = CW'(1) << (SHIFT - 1);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_DEC = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CW-1:0]    acc, acc_nxt;
  logic             err_nxt, ov_nxt, ol_nxt;
  logic [DW-1:0]    od_nxt;

  logic [CW-1:0]    lane_x    [LANES];
  logic [CW-1:0]    lane_y    [LANES];
  logic [CW-1:0]    lane_prod [LANES];
  logic [CW-1:0]    lane_term [LANES];
  logic [IDX_W-1:0] lane_idx  [LANES];
  logic [DW-1:0]    res_bus;
  logic [CW-1:0]    beat_sum;
  logic [CW-1:0]    rounded;
  logic [PW-1:0]    plain;
  logic             fire, last_beat;

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign fire      = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // Round-to-nearest decode: add half a plaintext step, keep the top PW bits.
  assign rounded = acc + ROUND;
  assign plain   = rounded[CW-1:SHIFT];

  // Per-lane datapath; lanes past entry n are padding and contribute nothing.
  always_comb begin
    res_bus  = '0;
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_x[i]    = in_x[i*CW +: CW];
      lane_y[i]    = in_y[i*CW +: CW];
      lane_idx[i]  = IDX_W'(cnt) * IDX_W'(LANES) + IDX_W'(i);
      lane_prod[i] = lane_x[i] * lane_y[i];
      lane_term[i] = '0;
      if (lane_idx[i] <= IDX_W'(DIMENSION)) begin
        res_bus[i*CW +: CW] = (mode_q == MODE_SUB) ? (lane_x[i] - lane_y[i])
                                                   : (lane_x[i] + lane_y[i]);
        // Entry 0 is b (key lane ignored); entries 1..n subtract a_j*s_j.
        lane_term[i] = (lane_idx[i] == '0) ? lane_x[i] : (CW'(0) - lane_prod[i]);
      end
      beat_sum = beat_sum + lane_term[i];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    err_nxt   = 1'b0;
    ov_nxt    = out_valid;
    ol_nxt    = out_last;
    od_nxt    = out_data;

    if (out_valid && out_ready) begin
      ov_nxt = 1'b0;
      ol_nxt = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          if (mode == MODE_RSV) begin
            err_nxt = 1'b1;
          end else begin
            mode_nxt  = mode;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (fire) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (mode_q == MODE_DEC) begin
            acc_nxt = acc + beat_sum;
          end else begin
            od_nxt = res_bus;
            ov_nxt = 1'b1;
            ol_nxt = last_beat;
          end
          if (last_beat) begin
            state_nxt = (mode_q == MODE_DEC) ? S_DECODE : S_FLUSH;
          end
        end
      end
      S_DECODE: begin
        od_nxt    = DW'(plain);
        ov_nxt    = 1'b1;
        ol_nxt    = 1'b1;
        state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (out_valid && out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over any command or transfer in the same cycle.
    if (clear) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      acc_nxt   = '0;
      err_nxt   = 1'b0;
      ov_nxt    = 1'b0;
      ol_nxt    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_ADD;
      cnt       <= '0;
      acc       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      mode_q    <= mode_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      err       <= err_nxt;
      out_valid <= ov_nxt;
      out_last  <= ol_nxt;
      out_data  <= od_nxt;
    end
  end

endmodule

// File: tb/tb_lwe_vector_engine.sv
// Directed self-checking bench for lwe_vector_engine (q = 2^10, p = 2^6, n = 10, 4 lanes).
module tb_lwe_vector_engine;

  localparam int CW    = 10;
  localparam int LANES = 4;
  localparam int DW    = CW * LANES;
  localparam int N     = 10;
  localparam int NENT  = 12;

  logic          clk = 1'b0;
  logic          rst, start, clear, in_valid, out_ready;
  logic [1:0]    mode;
  logic          busy, err, in_ready, out_valid, out_last;
  logic [DW-1:0] in_x, in_y, out_data;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] ex [NENT];
  logic [CW-1:0] ey [NENT];
  logic [CW-1:0] eo [NENT];

  always #5 clk = ~clk;

  lwe_vector_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .clear     (clear),
    .busy      (busy),
    .err       (err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input int k);
    for (int i = 0; i < LANES; i++) begin
      in_x[i*CW +: CW] = ex[k*LANES + i];
      in_y[i*CW +: CW] = ey[k*LANES + i];
    end
  endtask

  function automatic logic [DW-1:0] exp_beat(input int k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*CW +: CW] = eo[k*LANES + i];
    return v;
  endfunction

  task automatic fill(input int x, input int y, input int o);
    for (int e = 0; e < NENT; e++) begin
      ex[e] = CW'(x);
      ey[e] = CW'(y);
      eo[e] = (e <= N) ? CW'(o) : '0;
    end
  endtask

  task automatic start_cmd(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, err, in_ready, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, err, in_ready, out_valid, out_last});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_wrap();
    fill(1000, 50, 26);
    out_ready = 1'b1;
    start_cmd(2'd0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_first_ready: got %b expected 1", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      load_beat(k);
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(k) || out_last !== (k == 2)) begin
        errors++;
        $display("FAIL add_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 k, out_valid, out_data, out_last, exp_beat(k), (k == 2));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_done: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_sub_underflow();
    fill(3, 5, 1022);
    out_ready = 1'b1;
    start_cmd(2'd1);
    for (int k = 0; k < 3; k++) begin
      load_beat(k);
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(k) || out_last !== (k == 2)) begin
        errors++;
        $display("FAIL sub_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 k, out_valid, out_data, out_last, exp_beat(k), (k == 2));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  // b=82, a1=1, s1=2; y0 and the padding entry hold junk that must be ignored.
  task automatic dec_vec_plain5();
    fill(0, 0, 0);
    ex[0]  = 10'd82;  ey[0]  = 10'd7;
    ex[1]  = 10'd1;   ey[1]  = 10'd2;
    ex[11] = 10'd500; ey[11] = 10'd3;
  endtask

  task automatic test_dec_plain5();
    dec_vec_plain5();
    out_ready = 1'b0;
    start_cmd(2'd2);
    for (int k = 0; k < 3; k++) begin
      load_beat(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL dec5_decode_cycle: got v=%b busy=%b rdy=%b expected 0 1 0", out_valid, busy, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(5) || out_last !== 1'b1) begin
      errors++;
      $display("FAIL dec5_result: got v=%b d=%h l=%b expected 1 %h 1", out_valid, out_data, out_last, DW'(5));
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(5)) begin
      errors++;
      $display("FAIL dec5_hold: got v=%b d=%h expected 1 %h", out_valid, out_data, DW'(5));
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dec5_done: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_dec_round_wrap();
    fill(0, 0, 0);
    ex[0] = 10'd1020;
    out_ready = 1'b1;
    start_cmd(2'd2);
    for (int k = 0; k < 3; k++) begin
      load_beat(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL dec_wrap: got v=%b d=%h l=%b expected 1 0 1", out_valid, out_data, out_last);
    end
    tick();
  endtask

  task automatic test_backpressure();
    for (int e = 0; e < NENT; e++) begin
      ex[e] = CW'(e + 1);
      ey[e] = CW'(10 * e);
      eo[e] = (e <= N) ? CW'(11 * e + 1) : '0;
    end
    out_ready = 1'b1;
    start_cmd(2'd0);
    load_beat(0);
    in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    load_beat(1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_comb: got %b expected 0", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_beat(0)) begin
        errors++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b d=%h expected 0 1 %h",
                 c, in_ready, out_valid, out_data, exp_beat(0));
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_data !== exp_beat(1) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_beat1: got d=%h l=%b expected %h 0", out_data, out_last, exp_beat(1));
    end
    load_beat(2);
    tick();
    checks++;
    if (out_data !== exp_beat(2) || out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_beat2: got d=%h l=%b expected %h 1", out_data, out_last, exp_beat(2));
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_control();
    logic [DW-1:0] add8;
    add8 = {10'd8, 10'd8, 10'd8, 10'd8};
    mode  = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b busy=%b expected 1 0", err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_single: got err=%b busy=%b expected 0 0", err, busy);
    end
    // A SUB start while an ADD is running must not change the mode.
    fill(3, 5, 8);
    out_ready = 1'b1;
    start_cmd(2'd0);
    start = 1'b1;
    mode  = 2'd1;
    load_beat(0);
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (out_data !== add8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: got d=%h busy=%b expected %h 1", out_data, busy, add8);
    end
    // Clear with a beat offered: abort wins.
    load_beat(1);
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_run: got busy=%b v=%b l=%b rdy=%b expected 0 0 0 0",
               busy, out_valid, out_last, in_ready);
    end
  endtask

  task automatic test_rst_mid_dec();
    dec_vec_plain5();
    out_ready = 1'b0;
    start_cmd(2'd2);
    for (int k = 0; k < 3; k++) begin
      load_beat(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got v=%b expected 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, err, in_ready, out_valid, out_last} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_async: got ctrl=%b d=%h expected 00000 0",
               {busy, err, in_ready, out_valid, out_last}, out_data);
    end
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got v=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_x      = '0;
    in_y      = '0;
    test_reset();
    test_add_wrap();
    test_sub_underflow();
    test_dec_plain5();
    test_dec_round_wrap();
    test_backpressure();
    test_control();
    test_rst_mid_dec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
